// File: rtl/axi_req_master.sv
// Single-outstanding AXI4 master: turns simple engine requests into
// single-beat AXI4 reads/writes and hands back data or error status.
package axi_req_pkg;

  localparam int CFG_SYSBUS_ADDR_BITS  = 32;
  localparam int CFG_SYSBUS_DATA_BITS  = 64;
  localparam int CFG_SYSBUS_DATA_BYTES = CFG_SYSBUS_DATA_BITS / 8;
  localparam int CFG_SYSBUS_ID_BITS    = 5;
  localparam int CFG_SYSBUS_USER_BITS  = 1;

  typedef struct packed {
    logic                            aw_ready;
    logic                            w_ready;
    logic                            b_valid;
    logic [1:0]                      b_resp;
    logic                            ar_ready;
    logic                            r_valid;
    logic [1:0]                      r_resp;
    logic [CFG_SYSBUS_DATA_BITS-1:0] r_data;
  } axi4_master_in_type;

  typedef struct packed {
    logic                             aw_valid;
    logic [CFG_SYSBUS_ADDR_BITS-1:0]  aw_addr;
    logic [7:0]                       aw_len;
    logic [2:0]                       aw_size;
    logic [1:0]                       aw_burst;
    logic [3:0]                       aw_cache;
    logic [2:0]                       aw_prot;
    logic [CFG_SYSBUS_ID_BITS-1:0]    aw_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  aw_user;
    logic                             w_valid;
    logic [CFG_SYSBUS_DATA_BITS-1:0]  w_data;
    logic [CFG_SYSBUS_DATA_BYTES-1:0] w_strb;
    logic                             w_last;
    logic                             b_ready;
    logic                             ar_valid;
    logic [CFG_SYSBUS_ADDR_BITS-1:0]  ar_addr;
    logic [7:0]                       ar_len;
    logic [2:0]                       ar_size;
    logic [1:0]                       ar_burst;
    logic [3:0]                       ar_cache;
    logic [2:0]                       ar_prot;
    logic [CFG_SYSBUS_ID_BITS-1:0]    ar_id;
    logic [CFG_SYSBUS_USER_BITS-1:0]  ar_user;
    logic                             r_ready;
  } axi4_master_out_type;

endpackage

module axi_req_master
  import axi_req_pkg::*;
#(
  parameter logic [CFG_SYSBUS_ID_BITS-1:0]   req_id   = '0,
  parameter logic [CFG_SYSBUS_USER_BITS-1:0] req_user = '0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_req_valid,
  output logic                             o_req_ready,
  input  logic                             i_req_write,
  input  logic [CFG_SYSBUS_ADDR_BITS-1:0]  i_req_addr,
  input  logic [CFG_SYSBUS_DATA_BITS-1:0]  i_req_wdata,
  input  logic [CFG_SYSBUS_DATA_BYTES-1:0] i_req_wstrb,
  input  logic [7:0]                       i_req_bytes,
  output logic                             o_resp_valid,
  input  logic                             i_resp_ready,
  output logic [CFG_SYSBUS_DATA_BITS-1:0]  o_resp_rdata,
  output logic                             o_resp_err,
  input  axi4_master_in_type               i_xmsti,
  output axi4_master_out_type              o_xmsto
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B,
    S_RESP
  } state_e;

  state_e                           state_q, state_d;
  logic [CFG_SYSBUS_ADDR_BITS-1:0]  addr_q, addr_d;
  logic [CFG_SYSBUS_DATA_BITS-1:0]  wdata_q, wdata_d;
  logic [CFG_SYSBUS_DATA_BYTES-1:0] wstrb_q, wstrb_d;
  logic [2:0]                       size_q, size_d;
  logic [CFG_SYSBUS_DATA_BITS-1:0]  rdata_q, rdata_d;
  logic                             err_q, err_d;
  logic                             aw_done_q, aw_done_d;
  logic                             w_done_q, w_done_d;
  logic                             size_ok;
  logic                             ar_v, aw_v, w_v;

  // Only the SLVERR/DECERR bit of each response matters here.
  logic unused_resp_lsb;
  assign unused_resp_lsb = i_xmsti.b_resp[0] ^ i_xmsti.r_resp[0];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      size_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      size_q    <= size_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    size_d    = size_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    size_ok   = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          addr_d    = i_req_addr;
          wdata_d   = i_req_wdata;
          wstrb_d   = i_req_wstrb;
          rdata_d   = '0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          unique case (i_req_bytes)
            8'd1:    size_d = 3'd0;
            8'd2:    size_d = 3'd1;
            8'd4:    size_d = 3'd2;
            8'd8:    size_d = 3'd3;
            default: size_ok = 1'b0;
          endcase
          // Unsupported sizes never touch the bus.
          if (!size_ok) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (i_req_write) begin
            state_d = S_AW_W;
          end else begin
            state_d = S_AR;
          end
        end
      end
      S_AR: begin
        if (i_xmsti.ar_ready) state_d = S_R;
      end
      S_R: begin
        if (i_xmsti.r_valid) begin
          rdata_d = i_xmsti.r_data;
          err_d   = i_xmsti.r_resp[1];
          state_d = S_RESP;
        end
      end
      S_AW_W: begin
        aw_done_d = aw_done_q | i_xmsti.aw_ready;
        w_done_d  = w_done_q | i_xmsti.w_ready;
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        if (i_xmsti.b_valid) begin
          rdata_d = '0;
          err_d   = i_xmsti.b_resp[1];
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (i_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ar_v = (state_q == S_AR);
  assign aw_v = (state_q == S_AW_W) && !aw_done_q;
  assign w_v  = (state_q == S_AW_W) && !w_done_q;

  // Payload fields read as zero whenever their channel is idle.
  always_comb begin
    o_xmsto          = '0;
    o_xmsto.ar_valid = ar_v;
    o_xmsto.aw_valid = aw_v;
    o_xmsto.w_valid  = w_v;
    o_xmsto.r_ready  = (state_q == S_R);
    o_xmsto.b_ready  = (state_q == S_B);
    if (ar_v) begin
      o_xmsto.ar_addr  = addr_q;
      o_xmsto.ar_size  = size_q;
      o_xmsto.ar_burst = 2'b01;
      o_xmsto.ar_id    = req_id;
      o_xmsto.ar_user  = req_user;
    end
    if (aw_v) begin
      o_xmsto.aw_addr  = addr_q;
      o_xmsto.aw_size  = size_q;
      o_xmsto.aw_burst = 2'b01;
      o_xmsto.aw_id    = req_id;
      o_xmsto.aw_user  = req_user;
    end
    if (w_v) begin
      o_xmsto.w_data = wdata_q;
      o_xmsto.w_strb = wstrb_q;
      o_xmsto.w_last = 1'b1;
    end
  end

  assign o_req_ready  = (state_q == S_IDLE);
  assign o_resp_valid = (state_q == S_RESP);
  assign o_resp_rdata = o_resp_valid ? rdata_q : '0;
  assign o_resp_err   = o_resp_valid & err_q;

endmodule

// File: tb/tb_axi_req_master.sv
// Directed bench for axi_req_master: bench drives the AXI slave side
// cycle by cycle and checks each handshake and response.
module tb_axi_req_master;
  import axi_req_pkg::*;

  localparam logic [CFG_SYSBUS_ID_BITS-1:0]   REQ_ID   = 5'h13;
  localparam logic [CFG_SYSBUS_USER_BITS-1:0] REQ_USER = 1'b1;

  logic                             clk;
  logic                             rst;
  logic                             req_valid;
  logic                             req_ready;
  logic                             req_write;
  logic [CFG_SYSBUS_ADDR_BITS-1:0]  req_addr;
  logic [CFG_SYSBUS_DATA_BITS-1:0]  req_wdata;
  logic [CFG_SYSBUS_DATA_BYTES-1:0] req_wstrb;
  logic [7:0]                       req_bytes;
  logic                             resp_valid;
  logic                             resp_ready;
  logic [CFG_SYSBUS_DATA_BITS-1:0]  resp_rdata;
  logic                             resp_err;
  axi4_master_in_type               xmsti;
  axi4_master_out_type              xmsto;

  int checks = 0;
  int errors = 0;

  axi_req_master #(
    .req_id   (REQ_ID),
    .req_user (REQ_USER)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_write  (req_write),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .i_req_wstrb  (req_wstrb),
    .i_req_bytes  (req_bytes),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .i_xmsti      (xmsti),
    .o_xmsto      (xmsto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] a,
                       input logic [63:0] d, input logic [7:0] s,
                       input logic [7:0] n);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    req_bytes = n;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ready got=%b exp=1", req_ready);
    end
    checks++;
    if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_resp got v=%b e=%b d=%h exp 0", resp_valid, resp_err, resp_rdata);
    end
    checks++;
    if (xmsto !== '0) begin
      errors++;
      $display("FAIL reset_xmsto got=%h exp=0", xmsto);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    issue(1'b0, 32'h8000_0010, 64'h0, 8'h00, 8'd4);
    xmsti.ar_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++;
    if (xmsto.ar_valid !== 1'b1 || xmsto.ar_size !== 3'd2 || xmsto.ar_len !== 8'd0 ||
        xmsto.ar_addr !== 32'h8000_0010) begin
      errors++;
      $display("FAIL read_ar got v=%b sz=%0d len=%0d a=%h exp v=1 sz=2 len=0 a=80000010",
               xmsto.ar_valid, xmsto.ar_size, xmsto.ar_len, xmsto.ar_addr);
    end
    checks++;
    if (xmsto.ar_id !== REQ_ID || xmsto.ar_user !== REQ_USER || xmsto.ar_burst !== 2'b01) begin
      errors++;
      $display("FAIL read_ar_attr got id=%h user=%b burst=%b exp id=13 user=1 burst=01",
               xmsto.ar_id, xmsto.ar_user, xmsto.ar_burst);
    end
    tick();
    xmsti.ar_ready = 1'b0;
    checks++;
    if (xmsto.ar_valid !== 1'b0 || xmsto.r_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_r_ready got arv=%b rr=%b exp arv=0 rr=1", xmsto.ar_valid, xmsto.r_ready);
    end
    xmsti.r_valid = 1'b1;
    xmsti.r_data  = 64'h1122_3344_5566_7788;
    xmsti.r_resp  = 2'b00;
    tick();
    xmsti.r_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'h1122_3344_5566_7788 || resp_err !== 1'b0 ||
        xmsto.r_ready !== 1'b0) begin
      errors++;
      $display("FAIL read_resp got v=%b d=%h e=%b rr=%b exp v=1 d=1122334455667788 e=0 rr=0",
               resp_valid, resp_rdata, resp_err, xmsto.r_ready);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_done got rdy=%b rv=%b exp rdy=1 rv=0", req_ready, resp_valid);
    end
  endtask

  task automatic test_write_w_first();
    issue(1'b1, 32'h0000_0100, 64'hA5A5_0123_4567_89AB, 8'hFF, 8'd8);
    tick();
    req_valid = 1'b0;
    checks++;
    if (xmsto.aw_valid !== 1'b1 || xmsto.w_valid !== 1'b1 || xmsto.aw_size !== 3'd3 ||
        xmsto.w_data !== 64'hA5A5_0123_4567_89AB || xmsto.w_strb !== 8'hFF ||
        xmsto.w_last !== 1'b1) begin
      errors++;
      $display("FAIL write_start got awv=%b wv=%b sz=%0d wd=%h ws=%h wl=%b",
               xmsto.aw_valid, xmsto.w_valid, xmsto.aw_size, xmsto.w_data,
               xmsto.w_strb, xmsto.w_last);
    end
    xmsti.w_ready = 1'b1;
    tick();
    xmsti.w_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (xmsto.w_valid !== 1'b0 || xmsto.aw_valid !== 1'b1 || xmsto.b_ready !== 1'b0 ||
          xmsto.aw_addr !== 32'h100) begin
        errors++;
        $display("FAIL write_aw_hold[%0d] got wv=%b awv=%b br=%b a=%h exp wv=0 awv=1 br=0 a=100",
                 i, xmsto.w_valid, xmsto.aw_valid, xmsto.b_ready, xmsto.aw_addr);
      end
      if (i == 2) xmsti.aw_ready = 1'b1;
      tick();
    end
    xmsti.aw_ready = 1'b0;
    checks++;
    if (xmsto.aw_valid !== 1'b0 || xmsto.b_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_b_ready got awv=%b br=%b exp awv=0 br=1", xmsto.aw_valid, xmsto.b_ready);
    end
    xmsti.b_valid = 1'b1;
    xmsti.b_resp  = 2'b00;
    tick();
    xmsti.b_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL write_resp got v=%b e=%b d=%h exp v=1 e=0 d=0", resp_valid, resp_err, resp_rdata);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_read_slverr();
    issue(1'b0, 32'h0000_0040, 64'h0, 8'h00, 8'd2);
    tick();
    req_valid = 1'b0;
    checks++;
    if (xmsto.ar_size !== 3'd1) begin
      errors++;
      $display("FAIL slverr_size got=%0d exp=1", xmsto.ar_size);
    end
    xmsti.ar_ready = 1'b1;
    tick();
    xmsti.ar_ready = 1'b0;
    xmsti.r_valid  = 1'b1;
    xmsti.r_resp   = 2'b10;
    xmsti.r_data   = 64'hDEAD_BEEF_0000_0001;
    tick();
    xmsti.r_valid = 1'b0;
    xmsti.r_resp  = 2'b00;
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin
      errors++;
      $display("FAIL slverr_resp got v=%b e=%b exp v=1 e=1", resp_valid, resp_err);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_write_decerr();
    issue(1'b1, 32'h0000_0200, 64'h55, 8'h01, 8'd1);
    tick();
    req_valid = 1'b0;
    xmsti.aw_ready = 1'b1;
    xmsti.w_ready  = 1'b1;
    tick();
    xmsti.aw_ready = 1'b0;
    xmsti.w_ready  = 1'b0;
    checks++;
    if (xmsto.aw_valid !== 1'b0 || xmsto.w_valid !== 1'b0 || xmsto.b_ready !== 1'b1) begin
      errors++;
      $display("FAIL decerr_same_cycle got awv=%b wv=%b br=%b exp 0 0 1",
               xmsto.aw_valid, xmsto.w_valid, xmsto.b_ready);
    end
    xmsti.b_valid = 1'b1;
    xmsti.b_resp  = 2'b11;
    tick();
    xmsti.b_valid = 1'b0;
    xmsti.b_resp  = 2'b00;
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 64'h0) begin
      errors++;
      $display("FAIL decerr_resp got v=%b e=%b d=%h exp v=1 e=1 d=0", resp_valid, resp_err, resp_rdata);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_bad_size();
    issue(1'b0, 32'h0000_0300, 64'h0, 8'h00, 8'd3);
    tick();
    req_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 64'h0 ||
        xmsto.ar_valid !== 1'b0 || xmsto.aw_valid !== 1'b0 || xmsto.w_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_size got v=%b e=%b d=%h arv=%b awv=%b wv=%b exp v=1 e=1 d=0 no bus",
               resp_valid, resp_err, resp_rdata, xmsto.ar_valid, xmsto.aw_valid, xmsto.w_valid);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 32'h0000_0400, 64'h0, 8'h00, 8'd1);
    xmsti.ar_ready = 1'b1;
    tick();
    tick();
    xmsti.ar_ready = 1'b0;
    xmsti.r_valid  = 1'b1;
    xmsti.r_data   = 64'h0000_0000_0000_00C3;
    issue(1'b0, 32'h0000_0500, 64'h0, 8'h00, 8'd4);
    tick();
    xmsti.r_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 64'hC3 || resp_err !== 1'b0 ||
          req_ready !== 1'b0 || xmsto.ar_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_resp[%0d] got v=%b d=%h e=%b rdy=%b arv=%b exp v=1 d=c3 e=0 rdy=0 arv=0",
                 i, resp_valid, resp_rdata, resp_err, req_ready, xmsto.ar_valid);
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || xmsto.ar_valid !== 1'b0) begin
      errors++;
      $display("FAIL second_wait got rdy=%b rv=%b arv=%b exp 1 0 0", req_ready, resp_valid, xmsto.ar_valid);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (xmsto.ar_valid !== 1'b1 || xmsto.ar_addr !== 32'h500 || xmsto.ar_size !== 3'd2) begin
      errors++;
      $display("FAIL second_accept got arv=%b a=%h sz=%0d exp arv=1 a=500 sz=2",
               xmsto.ar_valid, xmsto.ar_addr, xmsto.ar_size);
    end
  endtask

  task automatic test_reset_mid_ar();
    tick();
    checks++;
    if (xmsto.ar_valid !== 1'b1) begin
      errors++;
      $display("FAIL ar_stall got arv=%b exp=1", xmsto.ar_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (xmsto.ar_valid !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ar got arv=%b rdy=%b rv=%b exp 0 1 0",
               xmsto.ar_valid, req_ready, resp_valid);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    req_bytes  = 8'd0;
    resp_ready = 1'b0;
    xmsti      = '0;
    test_reset();
    test_read();
    test_write_w_first();
    test_read_slverr();
    test_write_decerr();
    test_bad_size();
    test_back_to_back();
    test_reset_mid_ar();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_req_master.md
Name: axi_req_master

Overview:
- Single-outstanding AXI4 master adapter, the initiator-side counterpart of the AXI slave request bridge.
- Accepts simple request/response transactions (address, write flag, data, strobe, byte count) from an internal engine, e.g. a DMA or debug port.
- Issues each one as a single-beat AXI4 read or write on the system bus.
- Returns read data or the error status to the requester.

Parameters:
- req_id, 0, AXI ID driven on AR/AW (CFG_SYSBUS_ID_BITS wide).
- req_user, 0, AXI USER driven on AR/AW (CFG_SYSBUS_USER_BITS wide).

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  adapter can accept a request.
- i_req_write  in  1  1=write, 0=read.
- i_req_addr  in  CFG_SYSBUS_ADDR_BITS  byte address.
- i_req_wdata  in  CFG_SYSBUS_DATA_BITS  write data, bus-lane aligned.
- i_req_wstrb  in  CFG_SYSBUS_DATA_BYTES  write byte strobes.
- i_req_bytes  in  8  transfer size in bytes: 1, 2, 4 or 8.
- o_resp_valid  out  1  response valid.
- i_resp_ready  in  1  requester accepts response.
- o_resp_rdata  out  CFG_SYSBUS_DATA_BITS  read data; 0 for writes.
- o_resp_err  out  1  SLVERR/DECERR, or unsupported size.
- i_xmsti  in  axi4_master_in_type  AXI slave-to-master channels.
- o_xmsto  out  axi4_master_out_type  AXI master-to-slave channels.

Behaviour:
- Reset (i_rst=1 on a clock edge):
  - state=idle.
  - o_req_ready=1.
  - o_resp_valid=0, o_resp_rdata=0, o_resp_err=0.
  - All AXI valid/ready outputs 0; all other o_xmsto fields 0.
  - Reset mid-transaction abandons the transaction. Bus-side cleanup is the system reset's job.
- State machine states: idle, ar, r, aw_w, b, resp.
- o_req_ready=1 only in idle. Accept = i_req_valid && o_req_ready.
- Request capture on accept:
  - Latch addr, wdata, wstrb, write.
  - Convert bytes to AXI size: 1→0, 2→1, 4→2, 8→3.
  - Any other byte count: go to resp with err=1, rdata=0, and no bus activity.
- Read path:
  - idle→ar. ar_valid=1 from the cycle after accept.
  - ar_len=0, ar_burst=INCR, ar_id=req_id, ar_user=req_user, ar_prot=0, ar_cache=0.
  - On ar_valid && ar_ready: drop ar_valid and go to r with r_ready=1.
  - On r_valid: latch r_data, err = r_resp[1]; drop r_ready; go to resp.
- Write path:
  - idle→aw_w. aw_valid and w_valid both asserted from the cycle after accept.
  - AW fields as AR; w_last=1.
  - Each valid drops independently on its own handshake; aw_done/w_done flags track completion.
  - Handshakes may complete in either order or the same cycle.
  - When both done: go to b, b_ready=1.
  - On b_valid: err = b_resp[1], rdata=0; drop b_ready; go to resp.
- Response:
  - resp: o_resp_valid=1 and held stable until i_resp_ready.
  - Then → idle; o_req_ready=1 in the following cycle.
- Latency:
  - Minimum read: accept@T, ar_valid@T+1, r_valid@T+2, o_resp_valid@T+3.
  - Minimum write: accept@T, AW/W handshakes@T+1, b_valid@T+2, o_resp_valid@T+3.
- AXI valid signals never drop before their handshake. Outputs change only on clock edges.
- Exactly one transaction outstanding at a time; no bursts, no exclusive or locked access.

Test Plan:
- Read 4 bytes @0x8000_0010, slave ar_ready=1 and returns r_data=0x1122334455667788 OKAY next cycle → ar_size=2, ar_len=0, ar_id=req_id; o_resp_valid at accept+3 with rdata=0x1122334455667788, err=0.
- Write 8 bytes @0x100, wstrb=0xFF, slave asserts w_ready 3 cycles before aw_ready → w_valid drops after its handshake, aw_valid holds until its handshake; b_ready rises only after both; b_resp=OKAY → o_resp_valid, err=0, rdata=0.
- Read with r_resp=SLVERR(2'b10) → o_resp_err=1. Write with b_resp=DECERR(2'b11) → o_resp_err=1.
- Request with bytes=3 → no AR/AW valid ever asserted; o_resp_valid=1, err=1 at accept+1.
- Hold i_resp_ready=0 for 5 cycles while i_req_valid=1 → response stays stable, o_req_ready=0; second request accepted only after the response handshake.
- Assert i_rst while ar_valid=1 and ar_ready=0 → next cycle ar_valid=0, o_req_ready=1, o_resp_valid=0.
